// File: rtl/pwm_pkg.sv
// Shared constants and helpers for the PWM output stage: register map,
// PWM period limits and the per-pin output selection rule.
package pwm_pkg;

  localparam int unsigned ADDR_EN_OUT_LO = 0;
  localparam int unsigned ADDR_EN_OUT_HI = 1;
  localparam int unsigned ADDR_EN_PWM_LO = 2;
  localparam int unsigned ADDR_EN_PWM_HI = 3;
  localparam int unsigned ADDR_DUTY      = 4;

  localparam logic [7:0] PWM_TOP   = 8'd254;
  localparam logic [7:0] DUTY_FULL = 8'hFF;

  // A disabled pin is low; an enabled pin follows the PWM if selected, else high.
  function automatic logic [15:0] pin_mux(input logic [15:0] en_out,
                                          input logic [15:0] en_pwm,
                                          input logic        level);
    return en_out & (~en_pwm | {16{level}});
  endfunction

endpackage

// File: rtl/pwm_output_stage_if.sv
// Register-write bus from the SPI peripheral into the PWM output stage.
interface pwm_output_stage_if #(
  parameter int unsigned ADDR_W = 7
);
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_data;

  modport master (output wr_en, output wr_addr, output wr_data);
  modport slave  (input  wr_en, input  wr_addr, input  wr_data);
endinterface

// File: rtl/pwm_timebase.sv
// Prescaled 8-bit PWM counter with a duty shadow register that is only
// reloaded at the period wrap, so pins never see a partial period.
module pwm_timebase
  import pwm_pkg::*;
#(
  parameter int unsigned CLK_DIV = 13
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] duty_i,
  output logic       pwm_level_o,
  output logic       period_start_o
);

  localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic [7:0]       pwm_cnt_q, pwm_cnt_d;
  logic [7:0]       duty_active_q, duty_active_d;
  logic             period_start_q, period_start_d;
  logic             step, wrap;

  always_comb begin
    step           = (div_cnt_q == DIV_W'(CLK_DIV - 1));
    wrap           = step && (pwm_cnt_q == PWM_TOP);
    div_cnt_d      = step ? '0 : div_cnt_q + DIV_W'(1);
    pwm_cnt_d      = pwm_cnt_q;
    if (step) begin
      pwm_cnt_d = wrap ? '0 : pwm_cnt_q + 8'd1;
    end
    // duty_i is the pre-edge register value, so a write on the wrap cycle lands one period later
    duty_active_d  = wrap ? duty_i : duty_active_q;
    period_start_d = wrap;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt_q      <= '0;
      pwm_cnt_q      <= '0;
      duty_active_q  <= '0;
      period_start_q <= 1'b0;
    end else begin
      div_cnt_q      <= div_cnt_d;
      pwm_cnt_q      <= pwm_cnt_d;
      duty_active_q  <= duty_active_d;
      period_start_q <= period_start_d;
    end
  end

  assign pwm_level_o    = (duty_active_q == DUTY_FULL) || (pwm_cnt_q < duty_active_q);
  assign period_start_o = period_start_q;

endmodule

// File: rtl/pwm_output_stage.sv
// Register bank decoded from SPI writes plus registered muxing of 16 pins
// between forced-low, forced-high and the shared PWM waveform.
module pwm_output_stage
  import pwm_pkg::*;
#(
  parameter int unsigned CLK_DIV  = 13,
  parameter int unsigned MAX_ADDR = 4,
  parameter int unsigned ADDR_W   = 7
) (
  input  logic                clk,
  input  logic                rst_n,
  pwm_output_stage_if.slave   wr,
  output logic [7:0]          out_lo,
  output logic [7:0]          out_hi,
  output logic                period_start
);

  logic [15:0] en_out_q, en_out_d;
  logic [15:0] en_pwm_q, en_pwm_d;
  logic [15:0] pins_q, pins_d;
  logic [7:0]  duty_q, duty_d;
  logic        wr_hit;
  logic        pwm_level;

  always_comb begin
    en_out_d = en_out_q;
    en_pwm_d = en_pwm_q;
    duty_d   = duty_q;
    wr_hit   = wr.wr_en && (wr.wr_addr <= ADDR_W'(MAX_ADDR));
    if (wr_hit) begin
      case (wr.wr_addr)
        ADDR_W'(ADDR_EN_OUT_LO): en_out_d[7:0]  = wr.wr_data;
        ADDR_W'(ADDR_EN_OUT_HI): en_out_d[15:8] = wr.wr_data;
        ADDR_W'(ADDR_EN_PWM_LO): en_pwm_d[7:0]  = wr.wr_data;
        ADDR_W'(ADDR_EN_PWM_HI): en_pwm_d[15:8] = wr.wr_data;
        ADDR_W'(ADDR_DUTY):      duty_d         = wr.wr_data;
        default: ;
      endcase
    end
    pins_d = pin_mux(en_out_q, en_pwm_q, pwm_level);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_out_q <= '0;
      en_pwm_q <= '0;
      duty_q   <= '0;
      pins_q   <= '0;
    end else begin
      en_out_q <= en_out_d;
      en_pwm_q <= en_pwm_d;
      duty_q   <= duty_d;
      pins_q   <= pins_d;
    end
  end

  pwm_timebase #(
    .CLK_DIV(CLK_DIV)
  ) u_timebase (
    .clk           (clk),
    .rst_n         (rst_n),
    .duty_i        (duty_q),
    .pwm_level_o   (pwm_level),
    .period_start_o(period_start)
  );

  assign out_lo = pins_q[7:0];
  assign out_hi = pins_q[15:8];

endmodule

// File: tb/tb_pwm_output_stage.sv
// Bench for pwm_output_stage: two instances (CLK_DIV=13 and CLK_DIV=1) share one
// write bus and are checked each cycle against a cycle-count arithmetic model.
module tb_pwm_output_stage;

  localparam int unsigned DIV0 = 13;
  localparam int unsigned DIV1 = 1;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pwm_output_stage_if #(.ADDR_W(7)) bus ();

  logic [7:0] lo0, hi0, lo1, hi1;
  logic       ps0, ps1;

  pwm_output_stage #(.CLK_DIV(DIV0), .MAX_ADDR(4), .ADDR_W(7)) dut0 (
    .clk(clk), .rst_n(rst_n), .wr(bus), .out_lo(lo0), .out_hi(hi0), .period_start(ps0)
  );
  pwm_output_stage #(.CLK_DIV(DIV1), .MAX_ADDR(4), .ADDR_W(7)) dut1 (
    .clk(clk), .rst_n(rst_n), .wr(bus), .out_lo(lo1), .out_hi(hi1), .period_start(ps1)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Model state: edges since reset, register contents and the duty in force per instance.
  int unsigned e;
  logic [15:0] m_en_out, m_en_pwm;
  logic [7:0]  m_duty;
  logic [7:0]  m_da     [2];
  logic [15:0] exp_pins [2];
  logic        exp_ps   [2];
  int unsigned divs     [2];

  initial begin
    divs[0] = DIV0;
    divs[1] = DIV1;
  end

  // Edge n (1-based) ends a period when it completes a multiple of 255 PWM steps.
  function automatic bit is_wrap(input int unsigned n, input int unsigned d);
    return (n % d == 0) && ((n / d) % 255 == 0);
  endfunction

  // PWM level after `edges` clock edges, given the duty in force.
  function automatic bit level_at(input int unsigned edges, input int unsigned d,
                                  input logic [7:0] da);
    int unsigned cnt;
    cnt = (edges / d) % 255;
    return (da == 8'hFF) || (cnt < 32'(da));
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e        <= 0;
      m_en_out <= '0;
      m_en_pwm <= '0;
      m_duty   <= '0;
      for (int k = 0; k < 2; k++) begin
        m_da[k]     <= '0;
        exp_pins[k] <= '0;
        exp_ps[k]   <= 1'b0;
      end
    end else begin
      e <= e + 1;
      for (int k = 0; k < 2; k++) begin
        exp_pins[k] <= m_en_out & (~m_en_pwm | {16{level_at(e, divs[k], m_da[k])}});
        exp_ps[k]   <= is_wrap(e + 1, divs[k]);
        if (is_wrap(e + 1, divs[k])) m_da[k] <= m_duty;
      end
      if (bus.wr_en) begin
        case (bus.wr_addr)
          7'd0: m_en_out[7:0]  <= bus.wr_data;
          7'd1: m_en_out[15:8] <= bus.wr_data;
          7'd2: m_en_pwm[7:0]  <= bus.wr_data;
          7'd3: m_en_pwm[15:8] <= bus.wr_data;
          7'd4: m_duty         <= bus.wr_data;
          default: ;
        endcase
      end
    end
  end

  always @(negedge clk) begin : compare
    logic [15:0] ap;
    logic        aps;
    for (int k = 0; k < 2; k++) begin
      ap  = (k == 0) ? {hi0, lo0} : {hi1, lo1};
      aps = (k == 0) ? ps0 : ps1;
      n_tests++;
      if (ap !== exp_pins[k]) begin
        n_fail++;
        $display("FAIL pins dut%0d t=%0t: got %h, want %h", k, $time, ap, exp_pins[k]);
      end
      n_tests++;
      if (aps !== exp_ps[k]) begin
        n_fail++;
        $display("FAIL period_start dut%0d t=%0t: got %b, want %b", k, $time, aps, exp_ps[k]);
      end
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0t: got %0h, want %0h", nm, $time, act, exp);
    end
  endtask

  // Called at a negedge; the strobe is sampled by the following posedge.
  task automatic wr(input logic [6:0] a, input logic [7:0] d);
    bus.wr_en   = 1'b1;
    bus.wr_addr = a;
    bus.wr_data = d;
    @(negedge clk);
    bus.wr_en   = 1'b0;
  endtask

  task automatic wait_ps();
    bit got;
    int i;
    got = 1'b0;
    i   = 0;
    while (!got && i < 300) begin
      @(negedge clk);
      got = ps1;
      i++;
    end
    check("wait_ps_timeout", 32'(got), 32'd1);
  endtask

  // Starts at the negedge where dut1 shows period_start; counts pin0 high samples
  // over the 255 cycles of that period, optionally writing duty at sample wr_at.
  task automatic measure(input int wr_at, input logic [7:0] v, output int highs);
    highs = 0;
    for (int i = 1; i <= 255; i++) begin
      if (i == wr_at) begin
        bus.wr_en   = 1'b1;
        bus.wr_addr = 7'h04;
        bus.wr_data = v;
      end
      @(negedge clk);
      bus.wr_en = 1'b0;
      if (lo1[0]) highs++;
    end
    check("period_len", 32'(ps1), 32'd1);
  endtask

  initial begin : stim
    int h;
    bus.wr_en   = 1'b0;
    bus.wr_addr = '0;
    bus.wr_data = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_pins", {hi0, lo0, hi1, lo1}, 32'h0);
    check("reset_ps", {31'd0, ps0 | ps1}, 32'd0);

    // Async reset mid-period with all pins driven high
    wr(7'h00, 8'hFF);
    wr(7'h01, 8'hFF);
    @(negedge clk);
    check("all_high", {16'h0, hi0, lo0}, 32'hFFFF);
    repeat (20) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check("async_reset", {hi0, lo0, hi1, lo1}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("post_reset_pins", {hi0, lo0, hi1, lo1}, 32'h0);

    // Static enable latency
    wr(7'h00, 8'hF0);
    check("static_lo_1clk", 32'(lo0), 32'h00);
    @(negedge clk);
    check("static_lo_2clk", 32'(lo0), 32'hF0);
    wr(7'h01, 8'h01);
    check("static_hi_1clk", 32'(hi0), 32'h00);
    @(negedge clk);
    check("static_hi_2clk", 32'(hi0), 32'h01);

    // Illegal addresses are dropped
    wr(7'h05, 8'hFF);
    wr(7'h7F, 8'hFF);
    repeat (3) @(negedge clk);
    check("illegal_keep", {16'h0, hi0, lo0}, 32'h01F0);
    wr(7'h00, 8'h0F);
    @(negedge clk);
    check("legal_after_illegal", 32'(lo0), 32'h0F);

    // PWM on pin 0 of the CLK_DIV=1 instance
    wr(7'h00, 8'h01);
    wr(7'h01, 8'h00);
    wr(7'h02, 8'h01);
    wr(7'h03, 8'h00);
    wr(7'h04, 8'h80);
    wait_ps();
    measure(0, 8'h00, h);
    measure(0, 8'h00, h);
    check("duty80_high", 32'(h), 32'd128);

    // Extremes, then duty change landing on the wrap edge
    measure(1, 8'h00, h);
    check("duty80_again", 32'(h), 32'd128);
    measure(1, 8'hFF, h);
    check("duty00_high", 32'(h), 32'd0);
    measure(1, 8'h20, h);
    check("dutyFF_high", 32'(h), 32'd255);
    measure(255, 8'h40, h);
    check("duty20_high", 32'(h), 32'd32);
    measure(0, 8'h00, h);
    check("wrap_write_old", 32'(h), 32'd32);
    measure(0, 8'h00, h);
    check("wrap_write_new", 32'(h), 32'd64);

    // Random traffic, including illegal addresses and back-to-back strobes
    for (int i = 0; i < 8000; i++) begin
      if ($urandom_range(0, 9) < 3) begin
        bus.wr_en   = 1'b1;
        bus.wr_addr = ($urandom_range(0, 1) == 0) ? 7'($urandom_range(0, 4))
                                                  : 7'($urandom_range(0, 127));
        bus.wr_data = 8'($urandom_range(0, 255));
      end else begin
        bus.wr_en = 1'b0;
      end
      @(negedge clk);
    end
    bus.wr_en = 1'b0;
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
